// File: rtl/opt_pkg.sv
// Shared definitions for the opt encryptor/decryptor pair: widths, LFSR defaults, FSM states
// and the unrolled 8-step Galois LFSR advance.
package opt_pkg;

  localparam int unsigned LfsrW    = 16;
  localparam int unsigned KeyBytes = LfsrW / 8;
  localparam int unsigned KeyIdxW  = $clog2(KeyBytes) + 1;

  localparam logic [LfsrW-1:0] Taps     = 16'hB400;
  localparam logic [LfsrW-1:0] ZeroSeed = 16'hACE1;

  typedef enum logic [1:0] {
    StNoKey,
    StLoad,
    StRun
  } opt_state_e;

  // One keystream byte consumes eight Galois steps: shift right, fold taps on a 1 out.
  function automatic logic [LfsrW-1:0] lfsr_step8(logic [LfsrW-1:0] l, logic [LfsrW-1:0] taps);
    logic [LfsrW-1:0] r;
    r = l;
    for (int i = 0; i < 8; i++) begin
      if (r[0]) begin
        r = (r >> 1) ^ taps;
      end else begin
        r = r >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/opt_decryptor_if.sv
// Byte-stream bus between the pin mux (master) and the opt decryptor (slave).
// byte_count exists only when OPT_DEC_CNT_EN is defined.
interface opt_decryptor_if;
  logic       ena;
  logic [7:0] din;
  logic       din_valid;
  logic       din_is_key;
  logic [7:0] dout;
  logic       dout_valid;
  logic       key_ready;
  logic       err;
`ifdef OPT_DEC_CNT_EN
  logic [15:0] byte_count;
`endif

  modport master (
    output ena, din, din_valid, din_is_key,
    input  dout, dout_valid, key_ready, err
`ifdef OPT_DEC_CNT_EN
    , input byte_count
`endif
  );

  modport slave (
    input  ena, din, din_valid, din_is_key,
    output dout, dout_valid, key_ready, err
`ifdef OPT_DEC_CNT_EN
    , output byte_count
`endif
  );
endinterface

// File: rtl/opt_keystream.sv
// Keystream LFSR: byte-serial key load with all-zero seed substitution and 8-step advance.
// Shared unchanged between the encryptor and the decryptor.
module opt_keystream
  import opt_pkg::*;
#(
  parameter logic [LfsrW-1:0] LfsrTaps     = Taps,
  parameter logic [LfsrW-1:0] LfsrZeroSeed = ZeroSeed
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_we_i,
  input  logic [KeyIdxW-1:0] key_idx_i,
  input  logic               key_last_i,
  input  logic [7:0]         key_byte_i,
  input  logic               advance_i,
  output logic [7:0]         ks_o
);

  logic [LfsrW-1:0] lfsr_q, lfsr_d;
  logic [LfsrW-1:0] key_asm;

  always_comb begin
    key_asm = lfsr_q;
    for (int b = 0; b < int'(KeyBytes); b++) begin
      if (key_idx_i == KeyIdxW'(b)) begin
        key_asm[8*b +: 8] = key_byte_i;
      end
    end

    lfsr_d = lfsr_q;
    if (key_we_i) begin
      // An all-zero state would lock the LFSR, so a zero key runs from a fixed seed instead.
      lfsr_d = (key_last_i && (key_asm == '0)) ? LfsrZeroSeed : key_asm;
    end else if (advance_i) begin
      lfsr_d = lfsr_step8(lfsr_q, LfsrTaps);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign ks_o = lfsr_q[7:0];

endmodule

// File: rtl/opt_decryptor.sv
// Byte-serial stream decryptor: XORs ciphertext with the LFSR keystream after a key load.
// Optional OPT_DEC_CNT_EN adds a 16-bit count of decrypted bytes on the bus.
module opt_decryptor
  import opt_pkg::*;
#(
  parameter logic [LfsrW-1:0] LfsrTaps     = Taps,
  parameter logic [LfsrW-1:0] LfsrZeroSeed = ZeroSeed
) (
  input logic            clk,
  input logic            rst_n,
  opt_decryptor_if.slave bus
);

  opt_state_e         state_q;
  logic [KeyIdxW-1:0] idx_q;
  logic [7:0]         dout_q;
  logic               dout_valid_q;
  logic               key_ready_q;
  logic               err_q;
`ifdef OPT_DEC_CNT_EN
  logic [15:0]        cnt_q;
`endif

  logic               accept;
  logic               key_acc;
  logic               data_acc;
  logic [KeyIdxW-1:0] key_idx;
  logic               key_last;
  logic               advance;
  logic [7:0]         ks;

  always_comb begin
    accept   = bus.ena & bus.din_valid;
    key_acc  = accept & bus.din_is_key;
    data_acc = accept & ~bus.din_is_key;
    // Only LOAD continues a key; NOKEY and RUN (rekey) both start over at byte 0.
    key_idx  = (state_q == StLoad) ? idx_q : '0;
    key_last = (key_idx == KeyIdxW'(KeyBytes - 1));
    advance  = data_acc & (state_q == StRun);
  end

  opt_keystream #(
    .LfsrTaps     (LfsrTaps),
    .LfsrZeroSeed (LfsrZeroSeed)
  ) u_keystream (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_we_i   (key_acc),
    .key_idx_i  (key_idx),
    .key_last_i (key_last),
    .key_byte_i (bus.din),
    .advance_i  (advance),
    .ks_o       (ks)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StNoKey;
      idx_q        <= '0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      key_ready_q  <= 1'b0;
      err_q        <= 1'b0;
`ifdef OPT_DEC_CNT_EN
      cnt_q        <= 16'h0000;
`endif
    end else begin
      dout_valid_q <= 1'b0;
      if (key_acc) begin
        if (key_last) begin
          state_q     <= StRun;
          idx_q       <= '0;
          err_q       <= 1'b0;
          key_ready_q <= 1'b1;
`ifdef OPT_DEC_CNT_EN
          cnt_q       <= 16'h0000;
`endif
        end else begin
          state_q     <= StLoad;
          idx_q       <= key_idx + KeyIdxW'(1);
          key_ready_q <= 1'b0;
        end
      end else if (data_acc) begin
        if (state_q == StRun) begin
          dout_q       <= bus.din ^ ks;
          dout_valid_q <= 1'b1;
`ifdef OPT_DEC_CNT_EN
          cnt_q        <= cnt_q + 16'h0001;
`endif
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.key_ready  = key_ready_q;
  assign bus.err        = err_q;
`ifdef OPT_DEC_CNT_EN
  assign bus.byte_count = cnt_q;
`endif

endmodule

// File: tb/tb_opt_decryptor.sv
// Self-checking bench for opt_decryptor: vector table plus scoreboarded stream sequences.
module tb_opt_decryptor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  opt_decryptor_if bus ();

  opt_decryptor u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;
  logic [15:0] m_lfsr;

  typedef struct {
    logic [15:0] key;
    logic [7:0]  ct;
    logic [7:0]  pt;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference encryptor keystream: bitwise Galois steps, x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] step8(input logic [15:0] l);
    logic b;
    for (int i = 0; i < 8; i++) begin
      b = l[0];
      l = l >> 1;
      if (b) l = l ^ 16'hB400;
    end
    return l;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_dout_valid: got pulse with dout=%h, expected no pulse", bus.dout);
      end else begin
        mon_exp = exp_q.pop_front();
        check("dout", {8'h00, bus.dout}, {8'h00, mon_exp});
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic k);
    bus.din        = b;
    bus.din_is_key = k;
    bus.din_valid  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [15:0] key);
    send(key[7:0], 1'b1);
    send(key[15:8], 1'b1);
    m_lfsr = (key == 16'h0000) ? 16'hACE1 : key;
  endtask

  task automatic send_data(input logic [7:0] ct);
    exp_q.push_back(ct ^ m_lfsr[7:0]);
    m_lfsr = step8(m_lfsr);
    send(ct, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_pending", 16'(exp_q.size()), 16'h0000);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.din_valid = 1'b0;
    #7;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] pt;
    vecs[0] = '{key: 16'h1234, ct: 8'h34, pt: 8'h00};
    vecs[1] = '{key: 16'h0000, ct: 8'hE1, pt: 8'h00};
    vecs[2] = '{key: 16'hBEEF, ct: 8'h00, pt: 8'hEF};
    vecs[3] = '{key: 16'hABCD, ct: 8'hFF, pt: 8'h32};
    vecs[4] = '{key: 16'h00FF, ct: 8'h0F, pt: 8'hF0};

    rst_n = 1'b0;
    bus.ena = 1'b1;
    bus.din = 8'h00;
    bus.din_valid = 1'b0;
    bus.din_is_key = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);
    check("reset_dout", {8'h00, bus.dout}, 16'h0000);
    check("reset_dout_valid", {15'h0, bus.dout_valid}, 16'h0000);
    check("reset_key_ready", {15'h0, bus.key_ready}, 16'h0000);
    check("reset_err", {15'h0, bus.err}, 16'h0000);

    // Key 16'h1234 byte-serial, then first data uses k = key[7:0].
    send(8'h34, 1'b1);
    check("key_ready_after_1st", {15'h0, bus.key_ready}, 16'h0000);
    send(8'h12, 1'b1);
    m_lfsr = 16'h1234;
    check("key_ready_after_2nd", {15'h0, bus.key_ready}, 16'h0001);
    send_data(8'h34);
    check("first_dout_valid", {15'h0, bus.dout_valid}, 16'h0001);
    check("first_dout", {8'h00, bus.dout}, 16'h0000);
    idle(1);
    check("pulse_one_cycle", {15'h0, bus.dout_valid}, 16'h0000);
    drain();

    // Back-to-back stream of 16 bytes encrypted by the reference model.
    load_key(16'h1234);
    for (int i = 0; i < 16; i++) begin
      pt = 8'($urandom);
      send_data(pt ^ m_lfsr[7:0]);
      check("stream_no_gap", {15'h0, bus.dout_valid}, 16'h0001);
    end
    idle(1);
    drain();
`ifdef OPT_DEC_CNT_EN
    check("byte_count", bus.byte_count, 16'd16);
`endif

    // Rekey mid-stream with an ena-low pause between key bytes.
    send_data(8'h5A);
    send_data(8'hC3);
    send(8'h55, 1'b1);
    check("rekey_key_ready_drop", {15'h0, bus.key_ready}, 16'h0000);
    bus.ena = 1'b0;
    bus.din = 8'hAA;
    bus.din_is_key = 1'b0;
    bus.din_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ena_low_err_hold", {15'h0, bus.err}, 16'h0000);
    bus.ena = 1'b1;
    send(8'h66, 1'b1);
    m_lfsr = 16'h6655;
    check("rekey_key_ready", {15'h0, bus.key_ready}, 16'h0001);
    send_data(8'h55);
    send_data(8'h99);
    idle(1);
    drain();

    // Reset with a dout_valid pulse in flight, then data before any key.
    send(8'h10, 1'b0);
    rst_n = 1'b0;
    #1;
    check("reset_cancels_valid", {15'h0, bus.dout_valid}, 16'h0000);
    check("reset_key_ready", {15'h0, bus.key_ready}, 16'h0000);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'hAA, 1'b0);
    idle(2);
    check("nokey_err", {15'h0, bus.err}, 16'h0001);
    check("nokey_key_ready", {15'h0, bus.key_ready}, 16'h0000);
    load_key(16'hBEEF);
    check("beef_err_cleared", {15'h0, bus.err}, 16'h0000);
    check("beef_key_ready", {15'h0, bus.key_ready}, 16'h0001);

    // Vector table: each entry rekeys and decrypts one byte.
    for (int v = 0; v < 5; v++) begin
      load_key(vecs[v].key);
      check("vec_key_ready", {15'h0, bus.key_ready}, 16'h0001);
      exp_q.push_back(vecs[v].pt);
      m_lfsr = step8(m_lfsr);
      send(vecs[v].ct, 1'b0);
      check("vec_err", {15'h0, bus.err}, 16'h0000);
      idle(1);
      drain();
    end

    // Reset mid-load discards the partial key.
    send(8'h11, 1'b1);
    do_reset();
    send(8'h22, 1'b1);
    check("midload_restart", {15'h0, bus.key_ready}, 16'h0000);
    send(8'h33, 1'b1);
    m_lfsr = 16'h3322;
    check("midload_key_ready", {15'h0, bus.key_ready}, 16'h0001);
    send_data(8'h22);
    idle(2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/opt_decryptor.md
Name: opt_decryptor

Overview:
- Receive-side counterpart of the opt encryptor: recovers plaintext from a byte-serial ciphertext stream.
- Each ciphertext byte is XORed with a keystream byte from a 16-bit Galois LFSR seeded by a key that is loaded byte-serially before data.
- Sits behind the tt_um top-level pin mux: ui_in carries the data byte, uio_in carries the strobes, uo_out carries plaintext.

Parameters:
- LFSR_W, 16, keystream register width; must be a multiple of 8. Number of key bytes is KEY_BYTES = LFSR_W/8.
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1). Must match the encryptor.
- ZERO_SEED, 16'hACE1, substitute seed when the loaded key is all-zero (prevents LFSR lock-up).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; when 0, din_valid is ignored and all state holds.
- din  in  8  ciphertext byte, or key byte when din_is_key=1.
- din_valid  in  1  one-cycle strobe; din is sampled on this edge.
- din_is_key  in  1  qualifies din as a key byte (sampled with din_valid).
- dout  out  8  plaintext byte (registered).
- dout_valid  out  1  one-cycle pulse; dout is valid in the same cycle.
- key_ready  out  1  high when a full key is loaded (state RUN).
- err  out  1  sticky flag: data byte arrived without a full key. Cleared only by reset or by completing a key load.

Behaviour:
- Reset (async assert, sync release): state=NOKEY, lfsr=0, key byte index=0, dout=8'h00, dout_valid=0, key_ready=0, err=0.
- An accepted byte is any edge with ena & din_valid. No backpressure; one byte per cycle is sustainable.
- FSM states are NOKEY, LOAD, RUN.
- NOKEY:
  - Key byte: write into lfsr[7:0]; index=1; go to LOAD.
  - Data byte: dropped; err<=1.
- LOAD:
  - Key byte: write into lfsr[8*index +: 8]; index++.
  - When index reaches KEY_BYTES: go to RUN, err<=0, key_ready<=1. If the assembled key is 0, lfsr<=ZERO_SEED instead.
  - Data byte: dropped; err<=1; load progress is kept.
- RUN:
  - Data byte: dout<=din ^ lfsr[7:0]; dout_valid<=1 on the next edge (latency 1 cycle).
  - On the same edge, lfsr advances 8 Galois steps (unrolled combinationally). One step: b=l[0]; l=l>>1; if b, l^=TAPS.
  - Key byte: starts a rekey. Byte goes to lfsr[7:0]; index=1; key_ready<=0; go to LOAD. The old keystream is discarded.
- dout holds its last value between pulses. dout_valid is 0 on every cycle without an accepted RUN data byte.
- ena=0 mid-key-load: load progress is held, not lost.
- Reset mid-operation: returns to NOKEY immediately; any pending dout_valid is cancelled.
- Keystream byte k for byte n is lfsr[7:0] before its advance. For the first data byte after load, k = key[7:0].

Optional Feature:
- Macro: OPT_DEC_CNT_EN.
- Defined: adds output byte_count [15:0], a count of decrypted bytes.
  - Increments with each dout_valid and wraps 16'hFFFF -> 0.
  - Cleared to 0 by reset and when a key load completes.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package opt_pkg, also used by the encryptor:
  - state enum (NOKEY/LOAD/RUN) and the localparam widths;
  - TAPS and ZERO_SEED defaults;
  - a function lfsr_step8(l, taps) giving the 8-step advance.
- One natural sub-module, opt_keystream: the LFSR register with its load, seed-substitution and advance controls, instantiable unchanged by the encryptor.
- XOR, FSM and error flag stay in opt_decryptor.

Test Plan:
- Reset, then idle 5 cycles -> dout=00, dout_valid=0, key_ready=0, err=0.
- Load key bytes 34,12 (key 16'h1234), then data 8'h34 -> key_ready=1 after the 2nd key edge; dout=8'h00 with a one-cycle dout_valid one edge later.
- Encrypt 16 random bytes with a Python encryptor model (key 16'h1234), stream them back-to-back at one per cycle -> dout matches the plaintext exactly, 16 pulses, no gaps.
- Send data byte 8'hAA before any key -> no dout_valid, err=1. Then load key 16'hBEEF -> err=0, key_ready=1.
- Load key 16'h0000, then send data -> keystream is derived from 16'hACE1 (first k=8'hE1); a data byte of 8'hE1 decrypts to 8'h00.
- Rekey mid-stream (key byte 8'h55, deassert ena 3 cycles, then 8'h66), and separately assert rst_n low mid-load:
  - key_ready drops at the first key byte; the next data uses k=8'h55;
  - after reset, state=NOKEY and no spurious dout_valid appears.
